// File: rtl/prio_code_pkg.sv
// Shared types and constants for the priority-code link receiver.
package prio_code_pkg;

  localparam int CODE_W = 8;
  localparam int IDX_W  = 4;
  localparam int VEC_W  = 16;
  localparam logic [CODE_W-1:0] NONE_CODE = 8'hF0;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic             is_none;
    logic [IDX_W-1:0] idx;
  } prio_entry_t;

  // A code is legal if it names a request index 0..15 or is the no-request code.
  function automatic logic is_legal_code(input logic [CODE_W-1:0] code,
                                         input logic [CODE_W-1:0] none_code);
    return (code[CODE_W-1:IDX_W] == '0) || (code == none_code);
  endfunction

endpackage

// File: rtl/prio_code_fifo.sv
// Small synchronous FIFO of decoded priority entries; occupancy count carries
// one extra bit so full and empty are distinguishable.
module prio_code_fifo
  import prio_code_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  prio_entry_t push_data,
  input  logic        pop,
  output prio_entry_t pop_data,
  output logic        full,
  output logic        empty,
  output logic [CW-1:0] count
);

  prio_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  // Head entry is read combinationally so a pop can load the output the same edge.
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Priority-code receiver: buffers codes, decodes each to a request vector and
// holds it for HOLD_CYCLES. Define PRIO_DECODE_THERMO_EN for thermometer output.
module priority_code_decoder
  import prio_code_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter logic [CODE_W-1:0] NONE_CODE = prio_code_pkg::NONE_CODE,
  localparam int FW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [VEC_W-1:0]  vec_out,
  output logic              vec_valid,
  output logic              none_out,
  output logic              err_illegal,
  output logic [FW-1:0]     fill_level
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [HW-1:0]    r_cnt;
  logic [HW-1:0]    w_cnt_next;
  logic [VEC_W-1:0] r_vec;
  logic             r_valid;
  logic             r_none;
  logic             r_err;

  logic             w_legal;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  prio_entry_t      w_push_entry;
  prio_entry_t      w_pop_entry;
  logic [VEC_W-1:0] w_decoded;

  assign w_legal    = is_legal_code(code_in, NONE_CODE);
  assign code_ready = !rst && !w_full;
  assign w_accept   = code_valid && code_ready;
  assign w_push     = w_accept && w_legal;

  assign w_push_entry.is_none = (code_in == NONE_CODE);
  assign w_push_entry.idx     = (code_in == NONE_CODE) ? '0 : code_in[IDX_W-1:0];

  prio_code_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_pop_entry),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fill_level)
  );

  always_comb begin
    w_decoded = '0;
    if (!w_pop_entry.is_none) begin
`ifdef PRIO_DECODE_THERMO_EN
      w_decoded = {VEC_W{1'b1}} >> (IDX_W'(VEC_W - 1) - w_pop_entry.idx);
`else
      w_decoded = {{(VEC_W-1){1'b0}}, 1'b1} << w_pop_entry.idx;
`endif
    end
  end

  // Counter expiring with more data queued reloads directly: no idle bubble.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_cnt_next   = HOLD_LOAD;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_cnt_next = HOLD_LOAD;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_none  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_accept && !w_legal;
      if (w_pop) begin
        r_vec   <= w_decoded;
        r_valid <= 1'b1;
        r_none  <= w_pop_entry.is_none;
      end else if (w_state_next == IDLE) begin
        r_vec   <= '0;
        r_valid <= 1'b0;
        r_none  <= 1'b0;
      end
    end
  end

  assign vec_out     = r_vec;
  assign vec_valid   = r_valid;
  assign none_out    = r_none;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_priority_code_decoder.sv
// Directed bench for priority_code_decoder with a presentation scoreboard.
module tb_priority_code_decoder;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  code_in = 8'h00;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic [15:0] vec_out;
  logic        vec_valid;
  logic        none_out;
  logic        err_illegal;
  logic [2:0]  fill_level;

  typedef struct {
    logic [15:0] vec;
    logic        none;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mon_cnt = 0;
  int run_len = 0;
  int last_run = 0;
  int max_fill = 0;
  int presented = 0;

  priority_code_decoder #(
    .DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD),
    .NONE_CODE(8'hF0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .vec_out     (vec_out),
    .vec_valid   (vec_valid),
    .none_out    (none_out),
    .err_illegal (err_illegal),
    .fill_level  (fill_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_vec(input logic [7:0] c);
    logic [15:0] v;
    v = 16'h0000;
    if (c != 8'hF0) begin
`ifdef PRIO_DECODE_THERMO_EN
      for (int b = 0; b < 16; b++) begin
        if (b <= int'(c)) v[b] = 1'b1;
      end
`else
      v[c[3:0]] = 1'b1;
`endif
    end
    return v;
  endfunction

  function automatic logic legal(input logic [7:0] c);
    return (c < 8'd16) || (c == 8'hF0);
  endfunction

  // Monitor: samples on the falling edge, compares presented vectors in order.
  always @(negedge clk) begin
    chk("code_ready", code_ready, (rst == 1'b0) && (fill_level != 3'(DEPTH)));
    if (rst) begin
      sb.delete();
      mon_cnt = 0;
      run_len = 0;
      chk("rst_vec_valid", vec_valid, 0);
      chk("rst_vec_out", vec_out, 0);
      chk("rst_none_out", none_out, 0);
      chk("rst_err", err_illegal, 0);
      chk("rst_fill", fill_level, 0);
    end else begin
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
      if (vec_valid) begin
        run_len++;
        if (sb.size() == 0) begin
          chk("vec_valid_unexpected", vec_valid, 0);
        end else begin
          chk("vec_out", vec_out, sb[0].vec);
          chk("none_out", none_out, sb[0].none);
          mon_cnt++;
          if (mon_cnt == HOLD) begin
            void'(sb.pop_front());
            mon_cnt = 0;
            presented++;
          end
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        chk("idle_vec_out", vec_out, 0);
        chk("idle_none_out", none_out, 0);
        chk("hold_length", mon_cnt, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    exp_t e;
    bit done;
    done = 1'b0;
    code_in = c;
    code_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      if (code_ready) begin
        if (legal(c)) begin
          e.vec = exp_vec(c);
          e.none = (c == 8'hF0);
          sb.push_back(e);
        end
        done = 1'b1;
      end
      step();
    end
    code_valid = 1'b0;
    $display("send code=%02h accepted=%0d fill=%0d", c, done, fill_level);
    if (!done) chk("send_timeout", code_ready, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      if (sb.size() == 0 && !vec_valid) done = 1'b1;
      else step();
    end
    if (!done) chk("drain_timeout", vec_valid, 0);
  endtask

  initial begin
    int p0;
    logic [15:0] exp9;
`ifdef PRIO_DECODE_THERMO_EN
    exp9 = 16'h03FF;
`else
    exp9 = 16'h0200;
`endif

    // 1: reset with random input activity
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      code_in = 8'($urandom_range(0, 255));
      code_valid = 1'($urandom_range(0, 1));
      step();
      chk("ready_in_reset", code_ready, 0);
    end
    code_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", code_ready, 1);
    chk("fill_after_reset", fill_level, 0);
    step();

    // 2: single code, latency and hold length
    send(8'd9);
    chk("t2_valid_before_pop", vec_valid, 0);
    chk("t2_fill_after_accept", fill_level, 1);
    step();
    chk("t2_valid_first", vec_valid, 1);
    chk("t2_vec_first", vec_out, exp9);
    chk("t2_fill_after_pop", fill_level, 0);
    repeat (3) step();
    chk("t2_valid_last", vec_valid, 1);
    step();
    chk("t2_valid_end", vec_valid, 0);
    chk("t2_vec_end", vec_out, 0);
    chk("t2_run_len", last_run, HOLD);

    // 3: back-to-back entries, including NONE
    send(8'd15);
    send(8'd0);
    send(8'hF0);
    drain();
    chk("t3_run_len", last_run, 3 * HOLD);

    // 4: overfill with six codes
    max_fill = 0;
    p0 = presented;
    for (int i = 1; i <= 6; i++) send(8'(i));
    drain();
    chk("t4_max_fill", max_fill, DEPTH);
    chk("t4_presented", presented - p0, 6);
    chk("t4_fill_end", fill_level, 0);

    // 5: illegal codes are consumed and flagged
    send(8'h10);
    chk("t5_err_10", err_illegal, 1);
    chk("t5_fill_10", fill_level, 0);
    step();
    chk("t5_err_10_clear", err_illegal, 0);
    send(8'hFF);
    chk("t5_err_ff", err_illegal, 1);
    step();
    chk("t5_err_ff_clear", err_illegal, 0);
    chk("t5_valid", vec_valid, 0);
    chk("t5_fill", fill_level, 0);

    // 6: reset during the second cycle of HOLD
    send(8'd7);
    send(8'd8);
    send(8'd10);
    chk("t6_hold_valid", vec_valid, 1);
    chk("t6_hold_vec", vec_out, exp_vec(8'd7));
    rst = 1'b1;
    step();
    chk("t6_rst_valid", vec_valid, 0);
    chk("t6_rst_vec", vec_out, 0);
    chk("t6_rst_fill", fill_level, 0);
    rst = 1'b0;
    repeat (12) step();
    chk("t6_post_valid", vec_valid, 0);
    chk("t6_post_fill", fill_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
